hazard_fwd_unit: RTL and testbench
==================================

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the stall performance counter.
REQ-002 clk  input  1  pipeline clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 id_valid  input  1  ID stage holds a valid instruction.
REQ-005 id_rs1, id_rs2  input  5 each  ID source register indices, also driven to register-file rR1/rR2.
REQ-006 id_rs1_used, id_rs2_used  input  1 each  the instruction actually reads rs1/rs2.
REQ-007 id_rd, id_we, id_is_load  input  5/1/1  ID destination register, write enable, load flag.
REQ-008 flush  input  1  branch/jump redirect; kills the instruction in ID.
REQ-009 ex_wd, mem_wd, wb_wd  input  32 each  result data currently in the EX, MEM and WB stages.
REQ-010 risk_con1, risk_con2  output  1 each  forwarding override select to the register file.
REQ-011 risk_rd1, risk_rd2  output  32 each  forwarded operand data to the register file.
REQ-012 stall  output  1  freezes PC and IF/ID and inserts a bubble into EX.
REQ-013 stall_cnt  output  CNT_W  saturating count of stall cycles.

Function
REQ-014 The unit SHALL hold three shadow slots (EX, MEM, WB), each {rd[4:0], we, is_load}; a bubble has we=0.
REQ-015 Each edge: WB<=MEM and MEM<=EX unconditionally, with no backpressure.
REQ-016 Each edge: EX<=bubble if stall, flush, or !id_valid; else EX<={id_rd, id_we & (id_rd!=0), id_is_load}.
REQ-017 Stage match for operand n: slot.we=1 & slot.rd==id_rsn & id_rsn_used=1 & id_rsn!=0.
REQ-018 Register x0 SHALL never match, forward, or cause a stall.
REQ-019 Load-use: stall SHALL be 1 when id_valid=1 and either operand matches the EX slot with is_load=1.
REQ-020 Forward priority per operand is EX (non-load) > MEM > WB; data is ex_wd, mem_wd or wb_wd respectively.
REQ-021 risk_conn=1 and risk_rdn=selected data on a match; otherwise risk_conn=0 and risk_rdn=0.
REQ-022 When stall=1, risk_con1 and risk_con2 SHALL both be 0.
REQ-023 A WB-slot match SHALL forward, since the register file writes at the end of the same cycle.
REQ-024 flush=1 SHALL force stall=0 in the same cycle; flush has priority over a load-use stall.
REQ-025 A load-use stall SHALL last exactly 1 cycle; the next cycle the load sits in MEM and forwards mem_wd.
REQ-026 Forward/stall outputs are combinational from the slots and ID inputs, with zero-cycle latency.
REQ-027 stall_cnt SHALL increment on each edge where stall=1 and hold at all-ones (no wrap).

Reset
REQ-028 rst_n=0 SHALL immediately clear all slots to bubbles and stall_cnt to 0, independent of clk.
REQ-029 During and right after reset: stall=0, risk_con1/2=0, risk_rd1/2=0.
REQ-030 Reset asserted mid-stall SHALL drop stall in the same cycle.

Configuration
REQ-031 With macro HAZARD_FWD_EN defined, forwarding operates per REQ-019..REQ-025.
REQ-032 Without HAZARD_FWD_EN:
 - risk_con1/2 and risk_rd1/2 are tied to 0.
 - stall=1 on any operand match in the EX, MEM or WB slot, regardless of is_load.
 - flush still takes priority over stall.

Verification
REQ-033 add x5 in EX (ex_wd=0x11), ID reads rs1=x5 -> risk_con1=1, risk_rd1=0x11, stall=0.
REQ-034 x5 in both EX (0x22) and MEM (0x33), ID reads rs2=x5 -> risk_rd2=0x22 (EX wins).
REQ-035 lw x7 in EX, ID reads rs1=x7 -> stall=1 for one cycle, then risk_con1=1 with mem_wd=0xDEAD; stall_cnt +1.
REQ-036 Load-use with flush=1 in the same cycle -> stall=0; next cycle EX slot is a bubble.
REQ-037 Write to x0 in EX, ID reads x0 -> risk_con1=0, stall=0.
REQ-038 Without HAZARD_FWD_EN, add x3 then immediate read of x3 -> stall=1 for 3 cycles, risk_con always 0, stall_cnt=3.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: pipeline hazard detection, operand forwarding and stall counting.
//   Tracks the destination register of the instructions in EX, MEM and WB in three
//   shadow slots and compares them against the ID source operands.
//   Build option: define HAZARD_FWD_EN to enable EX/MEM/WB forwarding (only load-use
//   stalls); without it every RAW hazard stalls until the producer leaves WB.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_valid                    ID holds a valid instruction
//   id_rs1/2, id_rs1/2_used     ID source registers and whether they are read
//   id_rd, id_we, id_is_load    ID destination, write enable, load flag
//   flush                       redirect, kills the ID instruction
//   ex_wd, mem_wd, wb_wd        result data in EX, MEM, WB
//   risk_con1/2, risk_rd1/2     forwarding override select and data to the register file
//   stall                       freeze PC and IF/ID, bubble into EX
//   stall_cnt                   saturating stall cycle count
module hazard_fwd_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             flush,
    input  logic [31:0]      ex_wd,
    input  logic [31:0]      mem_wd,
    input  logic [31:0]      wb_wd,
    output logic             risk_con1,
    output logic             risk_con2,
    output logic [31:0]      risk_rd1,
    output logic [31:0]      risk_rd2,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       ex_we, mem_we, wb_we;
    logic       ex_ld, mem_ld, wb_ld;
    logic       m_ex1, m_mem1, m_wb1, m_ex2, m_mem2, m_wb2;
    logic       unused_ok;

    // x0 never matches: the rs != 0 term covers it even if a slot carried rd=0
    assign m_ex1  = id_rs1_used && id_rs1 != 5'd0 && ex_we  && ex_rd  == id_rs1;
    assign m_mem1 = id_rs1_used && id_rs1 != 5'd0 && mem_we && mem_rd == id_rs1;
    assign m_wb1  = id_rs1_used && id_rs1 != 5'd0 && wb_we  && wb_rd  == id_rs1;
    assign m_ex2  = id_rs2_used && id_rs2 != 5'd0 && ex_we  && ex_rd  == id_rs2;
    assign m_mem2 = id_rs2_used && id_rs2 != 5'd0 && mem_we && mem_rd == id_rs2;
    assign m_wb2  = id_rs2_used && id_rs2 != 5'd0 && wb_we  && wb_rd  == id_rs2;

`ifdef HAZARD_FWD_EN
    logic f_ex1, f_ex2;
    // a load in EX has no data yet, so it falls through to the older stages
    assign f_ex1     = m_ex1 && !ex_ld;
    assign f_ex2     = m_ex2 && !ex_ld;
    assign stall     = id_valid && !flush && (m_ex1 || m_ex2) && ex_ld;
    assign risk_con1 = !stall && (f_ex1 || m_mem1 || m_wb1);
    assign risk_con2 = !stall && (f_ex2 || m_mem2 || m_wb2);
    assign risk_rd1  = !risk_con1 ? 32'd0 : f_ex1 ? ex_wd : m_mem1 ? mem_wd : wb_wd;
    assign risk_rd2  = !risk_con2 ? 32'd0 : f_ex2 ? ex_wd : m_mem2 ? mem_wd : wb_wd;
    assign unused_ok = ^{mem_ld, wb_ld};
`else
    assign stall     = id_valid && !flush && (m_ex1 || m_mem1 || m_wb1 || m_ex2 || m_mem2 || m_wb2);
    assign risk_con1 = 1'b0;
    assign risk_con2 = 1'b0;
    assign risk_rd1  = 32'd0;
    assign risk_rd2  = 32'd0;
    assign unused_ok = ^{ex_wd, mem_wd, wb_wd, ex_ld, mem_ld, wb_ld};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {ex_rd, ex_we, ex_ld}    <= '0;
            {mem_rd, mem_we, mem_ld} <= '0;
            {wb_rd, wb_we, wb_ld}    <= '0;
            stall_cnt                <= '0;
        end else begin
            {wb_rd, wb_we, wb_ld}    <= {mem_rd, mem_we, mem_ld};
            {mem_rd, mem_we, mem_ld} <= {ex_rd, ex_we, ex_ld};
            {ex_rd, ex_we, ex_ld}    <= (stall || flush || !id_valid) ? 7'd0
                                        : {id_rd, id_we && id_rd != 5'd0, id_is_load};
            if (stall && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: scoreboard bench for hazard_fwd_unit (directed cases plus random stream).
module tb_hazard_fwd_unit;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic [4:0]       id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic             id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_we = 1'b0, id_is_load = 1'b0;
    logic             flush = 1'b0;
    logic [31:0]      ex_wd = '0, mem_wd = '0, wb_wd = '0;
    logic             risk_con1, risk_con2, stall;
    logic [31:0]      risk_rd1, risk_rd2;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .flush(flush),
        .ex_wd(ex_wd), .mem_wd(mem_wd), .wb_wd(wb_wd),
        .risk_con1(risk_con1), .risk_con2(risk_con2), .risk_rd1(risk_rd1), .risk_rd2(risk_rd2),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic             st, c1, c2;
        logic [31:0]      r1, r2;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             exp_q[$];
    int               n_cmp = 0, n_bad = 0;
    logic [4:0]       m_rd[3];
    logic             m_we[3], m_ld[3];
    logic [CNT_W-1:0] m_cnt = '0;
    logic             m_stall = 1'b0;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 3; s++) begin
            m_rd[s] = '0; m_we[s] = 1'b0; m_ld[s] = 1'b0;
        end
        m_cnt = '0; m_stall = 1'b0;
    endtask

    // walk WB -> MEM -> EX so the youngest producer overrides; a load in EX only flags a hazard
    task automatic model_op(input logic [4:0] rs, input logic used,
                            output logic hit, output logic ldh, output logic fwd, output logic [31:0] d);
        logic [31:0] wd[3];
        wd[0] = ex_wd; wd[1] = mem_wd; wd[2] = wb_wd;
        hit = 1'b0; ldh = 1'b0; fwd = 1'b0; d = '0;
        for (int s = 2; s >= 0; s--)
            if (used && rs != 5'd0 && m_we[s] && m_rd[s] == rs) begin
                hit = 1'b1;
                if (s == 0 && m_ld[0]) ldh = 1'b1;
                else begin fwd = 1'b1; d = wd[s]; end
            end
    endtask

    task automatic push_expect();
        logic h1, h2, l1, l2, f1, f2;
        logic [31:0] d1, d2;
        exp_t e;
        model_op(id_rs1, id_rs1_used, h1, l1, f1, d1);
        model_op(id_rs2, id_rs2_used, h2, l2, f2, d2);
        e.st  = id_valid && !flush && (FWD ? (l1 || l2) : (h1 || h2));
        e.c1  = FWD && f1 && !e.st;
        e.c2  = FWD && f2 && !e.st;
        e.r1  = e.c1 ? d1 : 32'd0;
        e.r2  = e.c2 ? d2 : 32'd0;
        e.cnt = m_cnt;
        m_stall = e.st;
        exp_q.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        e = exp_q.pop_front();
        check("stall", stall, e.st);
        check("con1", risk_con1, e.c1);
        check("con2", risk_con2, e.c2);
        check("rd1", risk_rd1, e.r1);
        check("rd2", risk_rd2, e.r2);
        check("stall_cnt", stall_cnt, e.cnt);
    endtask

    task automatic step(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                        input logic u2, input logic [4:0] rd, input logic we, input logic ld,
                        input logic fl, input logic [31:0] exd, input logic [31:0] memd,
                        input logic [31:0] wbd);
        @(negedge clk);
        id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
        id_rd = rd; id_we = we; id_is_load = ld; flush = fl;
        ex_wd = exd; mem_wd = memd; wb_wd = wbd;
        push_expect();
        #2;
        pop_compare();
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_clear();
        else begin
            if (m_stall && m_cnt != {CNT_W{1'b1}}) m_cnt++;
            for (int s = 2; s > 0; s--) begin
                m_rd[s] = m_rd[s-1]; m_we[s] = m_we[s-1]; m_ld[s] = m_ld[s-1];
            end
            if (m_stall || flush || !id_valid) begin
                m_rd[0] = '0; m_we[0] = 1'b0; m_ld[0] = 1'b0;
            end else begin
                m_rd[0] = id_rd; m_we[0] = id_we && id_rd != 5'd0; m_ld[0] = id_is_load;
            end
        end
    endtask

    task automatic issue(input logic [4:0] rd, input logic ld);
        step(1, 0, 0, 0, 0, rd, 1, ld, 0, 0, 0, 0);
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    initial begin
        model_clear();
        // reset with hazard-shaped inputs: outputs stay quiet
        step(1, 5, 1, 5, 1, 5, 1, 1, 0, 32'h1, 32'h2, 32'h3);
        check("rst_stall", stall, 1'b0);
        check("rst_con1", risk_con1, 1'b0);
        tick();
        #1 rst_n = 1'b1;

        // EX forward of an ALU result
        issue(5, 0);
        step(1, 5, 1, 0, 0, 0, 0, 0, 0, 32'h11, 32'h0, 32'h0);
        check("ex_fwd_con1", risk_con1, FWD);
        check("ex_fwd_rd1", risk_rd1, FWD ? 32'h11 : 32'h0);
        check("ex_fwd_stall", stall, !FWD);
        tick(); drain();

        // EX beats MEM for the same register
        issue(5, 0); issue(5, 0);
        step(1, 0, 0, 5, 1, 0, 0, 0, 0, 32'h22, 32'h33, 32'h0);
        check("prio_rd2", risk_rd2, FWD ? 32'h22 : 32'h0);
        tick(); drain();

        // load-use: one stall, then MEM forward
        issue(7, 1);
        step(1, 7, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        check("lu_stall", stall, 1'b1);
        check("lu_con1", risk_con1, 1'b0);
        tick();
        step(1, 7, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'hDEAD, 32'h0);
        check("lu_after_stall", stall, !FWD);
        check("lu_after_rd1", risk_rd1, FWD ? 32'hDEAD : 32'h0);
        tick(); drain();

        // flush beats load-use, and the flushed writer never reaches EX
        issue(7, 1);
        step(1, 7, 1, 0, 0, 9, 1, 0, 1, 32'h0, 32'h0, 32'h0);
        check("flush_stall", stall, 1'b0);
        tick();
        step(1, 9, 1, 0, 0, 0, 0, 0, 0, 32'h5, 32'h6, 32'h7);
        check("flush_bubble_con1", risk_con1, 1'b0);
        check("flush_bubble_stall", stall, 1'b0);
        tick(); drain();

        // x0 never forwards or stalls
        issue(0, 0);
        step(1, 0, 1, 0, 1, 0, 0, 0, 0, 32'h9, 32'h9, 32'h9);
        check("x0_con1", risk_con1, 1'b0);
        check("x0_stall", stall, 1'b0);
        tick(); drain();

        // reset asserted mid-stall drops stall immediately
        issue(7, 1);
        step(1, 7, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_stall", stall, 1'b0);
        check("rst_mid_cnt", stall_cnt, 0);
        tick();
        #1 rst_n = 1'b1;

        // back-to-back dependency through EX, MEM, WB
        issue(3, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 3, 1, 0, 0, 0, 0, 0, 0, 32'h1, 32'h2, 32'h3);
            check("dep_stall", stall, !FWD && i < 3);
            check("dep_rd1", risk_rd1, (FWD && i < 3) ? i + 1 : 0);
            if (i == 3) check("dep_cnt", stall_cnt, FWD ? 0 : 3);
            tick();
        end

        // random stream over a small register set to provoke hazards and saturate the counter
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 1'($urandom),
                 5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                 1'($urandom), $urandom_range(0, 7) == 0, $urandom, $urandom, $urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
